mpsoc_msi_slave_decoder: RTL

- 1-master-to-N-slave Wishbone decoder; the counterpart of the N-to-1 round-robin arbiter on the bus.
- Sits between an arbiter output (or a single master) and the peripheral slaves.
- Decodes the master address on cycle start and latches the selection for the whole bus cycle.
- Forwards the cycle to exactly one slave and muxes that slave's response back; unmapped accesses are answered with an error.

---
 rtl/mpsoc_msi_slave_decoder_if.sv | 59 +++++
 rtl/mpsoc_msi_slave_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_msi_slave_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_msi_slave_decoder_if
// Brief    : Wishbone bundle for the 1-to-N decoder: master side plus the
//            flattened per-slave side.
// Revision : 1.0
// ============================================================================
interface mpsoc_msi_slave_decoder_if #(
   parameter int NUM_SLAVES = 4,
   parameter int AW         = 32,
   parameter int DW         = 32
);
   logic [AW-1:0]              wbm_adr_i;
   logic [DW-1:0]              wbm_dat_i;
   logic [DW/8-1:0]            wbm_sel_i;
   logic                       wbm_we_i;
   logic                       wbm_cyc_i;
   logic                       wbm_stb_i;
   logic [2:0]                 wbm_cti_i;
   logic [1:0]                 wbm_bte_i;
   logic [DW-1:0]              wbm_dat_o;
   logic                       wbm_ack_o;
   logic                       wbm_err_o;
   logic                       wbm_rty_o;

   logic [NUM_SLAVES*AW-1:0]   wbs_adr_o;
   logic [NUM_SLAVES*DW-1:0]   wbs_dat_o;
   logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o;
   logic [NUM_SLAVES-1:0]      wbs_we_o;
   logic [NUM_SLAVES*3-1:0]    wbs_cti_o;
   logic [NUM_SLAVES*2-1:0]    wbs_bte_o;
   logic [NUM_SLAVES-1:0]      wbs_cyc_o;
   logic [NUM_SLAVES-1:0]      wbs_stb_o;
   logic [NUM_SLAVES*DW-1:0]   wbs_dat_i;
   logic [NUM_SLAVES-1:0]      wbs_ack_i;
   logic [NUM_SLAVES-1:0]      wbs_err_i;
   logic [NUM_SLAVES-1:0]      wbs_rty_i;

   // Decoder view
   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
             wbm_cti_i, wbm_bte_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o,
             wbs_cyc_o, wbs_stb_o,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
   );

   // Environment view (bus master plus the peripheral slaves)
   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
             wbm_cti_i, wbm_bte_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o,
             wbs_cyc_o, wbs_stb_o,
      output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
   );
endinterface
`default_nettype wire

// File: rtl/mpsoc_msi_slave_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_msi_slave_decoder
// Brief    : 1-master-to-N-slave Wishbone decoder; latches the decoded slave
//            for the whole bus cycle. Optional watchdog: MSI_DECODER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mpsoc_msi_slave_decoder #(
   parameter int                       NUM_SLAVES     = 4,
   parameter int                       AW             = 32,
   parameter int                       DW             = 32,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR     = '0,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK     = '0,
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input  wire logic                          clk,
   input  wire logic                          rst,
   mpsoc_msi_slave_decoder_if.slave           bus,
   output logic [$clog2(NUM_SLAVES)-1:0]      selection,
   output logic                               active
);
   localparam int SW = $clog2(NUM_SLAVES);

   if (NUM_SLAVES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("mpsoc_msi_slave_decoder: parameter out of range");
   end

`ifdef MSI_DECODER_TIMEOUT_EN
   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_DECODE_ERR = 2'd1,
      S_ACTIVE     = 2'd2,
      S_TIMEOUT    = 2'd3
   } state_t;
   localparam logic [15:0] TO_LIMIT = TIMEOUT_CYCLES[15:0];
   logic [15:0] to_cnt_q;
   logic        to_err_q;
`else
   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_DECODE_ERR = 2'd1,
      S_ACTIVE     = 2'd2
   } state_t;
`endif

   state_t                state_q;
   logic [SW-1:0]         selection_q;
   logic                  active_q;

   logic [NUM_SLAVES-1:0] match_d;
   logic                  hit_d;
   logic [SW-1:0]         idx_d;
   logic                  req;
   logic [NUM_SLAVES-1:0] sel_oh;
   logic                  sel_ack, sel_err, sel_rty;
   logic [DW-1:0]         sel_dat;
   logic [NUM_SLAVES-1:0] cyc_d, stb_d;
   logic                  ack_d, err_d, rty_d;
   logic [DW-1:0]         dat_d;

   assign req = bus.wbm_cyc_i & bus.wbm_stb_i;

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
      assign match_d[g] = (bus.wbm_adr_i & MATCH_MASK[g*AW +: AW]) == MATCH_ADDR[g*AW +: AW];
   end

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit_d = 1'b0;
      idx_d = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (match_d[i]) begin
            hit_d = 1'b1;
            idx_d = SW'(i);
         end
      end
   end

   always_comb begin
      sel_oh  = '0;
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_rty = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (selection_q == SW'(i)) begin
            sel_oh[i] = 1'b1;
            sel_ack   = bus.wbs_ack_i[i];
            sel_err   = bus.wbs_err_i[i];
            sel_rty   = bus.wbs_rty_i[i];
            sel_dat   = bus.wbs_dat_i[i*DW +: DW];
         end
      end
   end

   always_comb begin
      cyc_d = '0;
      stb_d = '0;
      ack_d = 1'b0;
      err_d = 1'b0;
      rty_d = 1'b0;
      dat_d = '0;
      case (state_q)
         S_ACTIVE: begin
            cyc_d = sel_oh & {NUM_SLAVES{bus.wbm_cyc_i}};
            stb_d = sel_oh & {NUM_SLAVES{bus.wbm_stb_i}};
            ack_d = sel_ack & req;
            err_d = sel_err & req;
            rty_d = sel_rty & req;
            dat_d = sel_dat;
         end
         S_DECODE_ERR: err_d = req;
`ifdef MSI_DECODER_TIMEOUT_EN
         S_TIMEOUT:    err_d = to_err_q;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         selection_q <= '0;
         active_q    <= 1'b0;
`ifdef MSI_DECODER_TIMEOUT_EN
         to_cnt_q    <= '0;
         to_err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  if (hit_d) begin
                     state_q     <= S_ACTIVE;
                     selection_q <= idx_d;
                     active_q    <= 1'b1;
`ifdef MSI_DECODER_TIMEOUT_EN
                     to_cnt_q    <= '0;
`endif
                  end else begin
                     state_q <= S_DECODE_ERR;
                  end
               end
            end
            S_DECODE_ERR: begin
               if (!bus.wbm_cyc_i) state_q <= S_IDLE;
            end
            S_ACTIVE: begin
               if (!bus.wbm_cyc_i) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end
`ifdef MSI_DECODER_TIMEOUT_EN
               else if (ack_d | err_d | rty_d) begin
                  to_cnt_q <= '0;
               end else if (bus.wbm_stb_i) begin
                  if (to_cnt_q + 16'd1 == TO_LIMIT) begin
                     state_q  <= S_TIMEOUT;
                     active_q <= 1'b0;
                     to_err_q <= 1'b1;
                  end
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
`endif
            end
`ifdef MSI_DECODER_TIMEOUT_EN
            S_TIMEOUT: begin
               to_err_q <= 1'b0;
               if (!bus.wbm_cyc_i) state_q <= S_IDLE;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.wbs_adr_o = {NUM_SLAVES{bus.wbm_adr_i}};
   assign bus.wbs_dat_o = {NUM_SLAVES{bus.wbm_dat_i}};
   assign bus.wbs_sel_o = {NUM_SLAVES{bus.wbm_sel_i}};
   assign bus.wbs_we_o  = {NUM_SLAVES{bus.wbm_we_i}};
   assign bus.wbs_cti_o = {NUM_SLAVES{bus.wbm_cti_i}};
   assign bus.wbs_bte_o = {NUM_SLAVES{bus.wbm_bte_i}};
   assign bus.wbs_cyc_o = cyc_d;
   assign bus.wbs_stb_o = stb_d;
   assign bus.wbm_ack_o = ack_d;
   assign bus.wbm_err_o = err_d;
   assign bus.wbm_rty_o = rty_d;
   assign bus.wbm_dat_o = dat_d;
   assign selection     = selection_q;
   assign active        = active_q;
endmodule
`default_nettype wire
